wb_regfile: RTL and testbench

- Architectural state sink for the write-back stage: 32 x 32-bit general-purpose register file plus the HI/LO register pair.
- Consumes the write-back bundle leaving the MEM/WB pipeline register: GPR write (wdata/wd/wreg) and HI/LO write (whilo/hi/lo).
- Serves two ID-stage GPR read ports and one HI/LO read port to EX.
- Same-cycle write-to-read bypass, so a WB write and an ID read of the same register need no extra stall cycle.

---
 rtl/wb_regfile_if.sv | 32 +++
 rtl/wb_regfile.sv | 64 ++++++
 tb/tb_wb_regfile.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - write-back, GPR read and HI/LO read bundle for the register file
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [DATA_W-1:0] wb_wdata;
    logic [ADDR_W-1:0] wb_wd;
    logic              wb_wreg;
    logic              wb_whilo;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;

    modport master (
        output wb_wdata, wb_wd, wb_wreg, wb_whilo, wb_hi, wb_lo,
        output re1, raddr1, re2, raddr2,
        input  rdata1, rdata2, hi_o, lo_o
    );

    modport slave (
        input  wb_wdata, wb_wd, wb_wreg, wb_whilo, wb_hi, wb_lo,
        input  re1, raddr1, re2, raddr2,
        output rdata1, rdata2, hi_o, lo_o
    );
endinterface

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - 32x32 GPR file plus HI/LO with same-cycle write-to-read bypass
module wb_regfile #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int REG_NUM = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_regfile_if.slave bus
);
    logic [DATA_W-1:0] gpr [REG_NUM];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    // Entry 0 is never written, so it holds its reset value of zero forever.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                gpr[i] <= '0;
            end
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (bus.wb_wreg && (bus.wb_wd != '0)) begin
                gpr[bus.wb_wd] <= bus.wb_wdata;
            end
            if (bus.wb_whilo) begin
                hi_q <= bus.wb_hi;
                lo_q <= bus.wb_lo;
            end
        end
    end

    always_comb begin
        bus.rdata1 = '0;
        if (rst_n && bus.re1 && (bus.raddr1 != '0)) begin
            if (bus.wb_wreg && (bus.wb_wd == bus.raddr1)) begin
                bus.rdata1 = bus.wb_wdata;
            end else begin
                bus.rdata1 = gpr[bus.raddr1];
            end
        end
    end

    always_comb begin
        bus.rdata2 = '0;
        if (rst_n && bus.re2 && (bus.raddr2 != '0)) begin
            if (bus.wb_wreg && (bus.wb_wd == bus.raddr2)) begin
                bus.rdata2 = bus.wb_wdata;
            end else begin
                bus.rdata2 = gpr[bus.raddr2];
            end
        end
    end

    always_comb begin
        bus.hi_o = '0;
        bus.lo_o = '0;
        if (rst_n) begin
            bus.hi_o = bus.wb_whilo ? bus.wb_hi : hi_q;
            bus.lo_o = bus.wb_whilo ? bus.wb_lo : lo_q;
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed self-checking bench for wb_regfile
module tb_wb_regfile;
    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .REG_NUM(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wb_wdata = '0;
        bus.wb_wd    = '0;
        bus.wb_wreg  = 1'b0;
        bus.wb_whilo = 1'b0;
        bus.wb_hi    = '0;
        bus.wb_lo    = '0;
        bus.re1      = 1'b0;
        bus.raddr1   = '0;
        bus.re2      = 1'b0;
        bus.raddr2   = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        bus.re1 = 1'b1; bus.raddr1 = 5'd5;
        bus.re2 = 1'b1; bus.raddr2 = 5'd31;
        tick();
        tick();
        total++;
        if (bus.rdata1 !== 32'h0) $display("FAIL reset_hold_rdata1 got %h want %h", bus.rdata1, 32'h0);
        else passed++;
        rst_n = 1'b1;
        #1;
        total++;
        if (bus.rdata1 !== 32'h0) $display("FAIL reset_rdata1 got %h want %h", bus.rdata1, 32'h0);
        else passed++;
        total++;
        if (bus.rdata2 !== 32'h0) $display("FAIL reset_rdata2 got %h want %h", bus.rdata2, 32'h0);
        else passed++;
        total++;
        if (bus.hi_o !== 32'h0) $display("FAIL reset_hi got %h want %h", bus.hi_o, 32'h0);
        else passed++;
        total++;
        if (bus.lo_o !== 32'h0) $display("FAIL reset_lo got %h want %h", bus.lo_o, 32'h0);
        else passed++;
    endtask

    task automatic test_write_read();
        idle_inputs();
        bus.wb_wreg = 1'b1; bus.wb_wd = 5'd3; bus.wb_wdata = 32'hDEADBEEF;
        tick();
        bus.wb_wreg = 1'b0; bus.wb_wd = '0; bus.wb_wdata = '0;
        bus.re1 = 1'b1; bus.raddr1 = 5'd3;
        #1;
        total++;
        if (bus.rdata1 !== 32'hDEADBEEF) $display("FAIL write_read got %h want %h", bus.rdata1, 32'hDEADBEEF);
        else passed++;
        bus.re1 = 1'b0;
        #1;
        total++;
        if (bus.rdata1 !== 32'h0) $display("FAIL read_disabled got %h want %h", bus.rdata1, 32'h0);
        else passed++;
        bus.raddr1 = 'x;
        #1;
        total++;
        if (bus.rdata1 !== 32'h0) $display("FAIL read_disabled_xaddr got %h want %h", bus.rdata1, 32'h0);
        else passed++;
    endtask

    task automatic test_bypass();
        idle_inputs();
        bus.wb_wreg = 1'b1; bus.wb_wd = 5'd7; bus.wb_wdata = 32'h1234_5678;
        bus.re1 = 1'b1; bus.raddr1 = 5'd7;
        bus.re2 = 1'b1; bus.raddr2 = 5'd7;
        #1;
        total++;
        if (bus.rdata1 !== 32'h1234_5678) $display("FAIL bypass_rdata1 got %h want %h", bus.rdata1, 32'h1234_5678);
        else passed++;
        total++;
        if (bus.rdata2 !== 32'h1234_5678) $display("FAIL bypass_rdata2 got %h want %h", bus.rdata2, 32'h1234_5678);
        else passed++;
        tick();
        bus.wb_wreg = 1'b0; bus.wb_wd = '0; bus.wb_wdata = 32'hBAD0_BAD0;
        #1;
        total++;
        if (bus.rdata1 !== 32'h1234_5678) $display("FAIL stored_rdata1 got %h want %h", bus.rdata1, 32'h1234_5678);
        else passed++;
        total++;
        if (bus.rdata2 !== 32'h1234_5678) $display("FAIL stored_rdata2 got %h want %h", bus.rdata2, 32'h1234_5678);
        else passed++;
    endtask

    task automatic test_two_ports();
        idle_inputs();
        bus.wb_wreg = 1'b1; bus.wb_wd = 5'd10; bus.wb_wdata = 32'h0000_0A0A;
        tick();
        bus.wb_wd = 5'd20; bus.wb_wdata = 32'h0000_1414;
        bus.re1 = 1'b1; bus.raddr1 = 5'd10;
        bus.re2 = 1'b1; bus.raddr2 = 5'd20;
        #1;
        total++;
        if (bus.rdata1 !== 32'h0000_0A0A) $display("FAIL two_port_rdata1 got %h want %h", bus.rdata1, 32'h0000_0A0A);
        else passed++;
        total++;
        if (bus.rdata2 !== 32'h0000_1414) $display("FAIL two_port_rdata2_bypass got %h want %h", bus.rdata2, 32'h0000_1414);
        else passed++;
        tick();
        bus.wb_wreg = 1'b0;
        bus.raddr1 = 5'd20; bus.raddr2 = 5'd3;
        #1;
        total++;
        if (bus.rdata1 !== 32'h0000_1414) $display("FAIL two_port_r20 got %h want %h", bus.rdata1, 32'h0000_1414);
        else passed++;
        total++;
        if (bus.rdata2 !== 32'hDEADBEEF) $display("FAIL two_port_r3 got %h want %h", bus.rdata2, 32'hDEADBEEF);
        else passed++;
    endtask

    task automatic test_reg_zero();
        idle_inputs();
        bus.wb_wreg = 1'b1; bus.wb_wd = 5'd0; bus.wb_wdata = 32'hFFFF_FFFF;
        bus.re1 = 1'b1; bus.raddr1 = 5'd0;
        #1;
        total++;
        if (bus.rdata1 !== 32'h0) $display("FAIL reg0_same_cycle got %h want %h", bus.rdata1, 32'h0);
        else passed++;
        tick();
        bus.wb_wreg = 1'b0;
        #1;
        total++;
        if (bus.rdata1 !== 32'h0) $display("FAIL reg0_next_cycle got %h want %h", bus.rdata1, 32'h0);
        else passed++;
    endtask

    task automatic test_hilo();
        idle_inputs();
        bus.wb_whilo = 1'b1; bus.wb_hi = 32'hAAAA_0001; bus.wb_lo = 32'h5555_0002;
        bus.wb_wreg = 1'b1; bus.wb_wd = 5'd9; bus.wb_wdata = 32'h42;
        #1;
        total++;
        if (bus.hi_o !== 32'hAAAA_0001) $display("FAIL hi_bypass got %h want %h", bus.hi_o, 32'hAAAA_0001);
        else passed++;
        total++;
        if (bus.lo_o !== 32'h5555_0002) $display("FAIL lo_bypass got %h want %h", bus.lo_o, 32'h5555_0002);
        else passed++;
        tick();
        idle_inputs();
        bus.wb_hi = 32'h1111_1111; bus.wb_lo = 32'h2222_2222;
        bus.re1 = 1'b1; bus.raddr1 = 5'd9;
        #1;
        total++;
        if (bus.hi_o !== 32'hAAAA_0001) $display("FAIL hi_stored got %h want %h", bus.hi_o, 32'hAAAA_0001);
        else passed++;
        total++;
        if (bus.lo_o !== 32'h5555_0002) $display("FAIL lo_stored got %h want %h", bus.lo_o, 32'h5555_0002);
        else passed++;
        total++;
        if (bus.rdata1 !== 32'h42) $display("FAIL hilo_concurrent_gpr got %h want %h", bus.rdata1, 32'h42);
        else passed++;
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        bus.wb_wreg = 1'b1; bus.wb_wd = 5'd4; bus.wb_wdata = 32'h99;
        tick();
        idle_inputs();
        bus.re1 = 1'b1; bus.raddr1 = 5'd4;
        // Short reset pulse that ends before the next edge must not touch stored state.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        total++;
        if (bus.rdata1 !== 32'h99) $display("FAIL reset_glitch_r4 got %h want %h", bus.rdata1, 32'h99);
        else passed++;
        rst_n = 1'b0;
        bus.wb_wreg = 1'b1; bus.wb_wd = 5'd4; bus.wb_wdata = 32'h77;
        #1;
        total++;
        if (bus.rdata1 !== 32'h0) $display("FAIL in_reset_rdata1 got %h want %h", bus.rdata1, 32'h0);
        else passed++;
        total++;
        if (bus.hi_o !== 32'h0) $display("FAIL in_reset_hi got %h want %h", bus.hi_o, 32'h0);
        else passed++;
        total++;
        if (bus.lo_o !== 32'h0) $display("FAIL in_reset_lo got %h want %h", bus.lo_o, 32'h0);
        else passed++;
        tick();
        rst_n = 1'b1;
        bus.wb_wreg = 1'b0; bus.wb_wd = '0; bus.wb_wdata = '0;
        bus.re2 = 1'b1; bus.raddr2 = 5'd9;
        #1;
        total++;
        if (bus.rdata1 !== 32'h0) $display("FAIL after_reset_r4 got %h want %h", bus.rdata1, 32'h0);
        else passed++;
        total++;
        if (bus.rdata2 !== 32'h0) $display("FAIL after_reset_r9 got %h want %h", bus.rdata2, 32'h0);
        else passed++;
        total++;
        if (bus.hi_o !== 32'h0) $display("FAIL after_reset_hi got %h want %h", bus.hi_o, 32'h0);
        else passed++;
        total++;
        if (bus.lo_o !== 32'h0) $display("FAIL after_reset_lo got %h want %h", bus.lo_o, 32'h0);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        idle_inputs();
        test_reset();
        test_write_read();
        test_bypass();
        test_two_ports();
        test_reg_zero();
        test_hilo();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
